// File: rtl/ber_exp_cmp.sv
// Bernoulli-exponential decision stage for the Falcon Gaussian sampler.
// Compares PRNG chunks MSB-first against z = ((2*y)-1) >> s; b=1 when rnd < z.
module ber_exp_cmp #(
  parameter int Z_W     = 64,
  parameter int CHUNK_W = 8,
  parameter int S_W     = 8,
  localparam int NCH    = Z_W / CHUNK_W,
  localparam int CNT_W  = $clog2(NCH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [Z_W-1:0]     y_in,
  input  logic [S_W-1:0]     s,
  input  logic               ct_mode,
  input  logic               y_stb,
  output logic               y_ack,
  input  logic [CHUNK_W-1:0] rnd,
  input  logic               rnd_stb,
  output logic               rnd_ack,
  output logic               rnd_req,
  output logic               b,
  output logic               b_stb,
  input  logic               b_ack,
  output logic [CNT_W-1:0]   chunks_used
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SH_W  = $clog2(Z_W);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PREP = 2'd1;
  localparam logic [1:0] REQ  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  if (Z_W % CHUNK_W != 0) begin : g_bad_chunk_w
    $error("ber_exp_cmp: Z_W must be a multiple of CHUNK_W");
  end

  logic [1:0]         state_q, state_d;
  logic [Z_W-1:0]     y_q, y_d;
  logic [Z_W-1:0]     z_q, z_d;
  logic [SH_W-1:0]    s_q, s_d;
  logic               ct_q, ct_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               decided_q, decided_d;
  logic               res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               y_ack_q, y_ack_d;
  logic               rnd_req_q, rnd_req_d;
  logic               b_q, b_d;
  logic               b_stb_q, b_stb_d;
  logic [CNT_W-1:0]   cu_q, cu_d;

  logic [CHUNK_W-1:0] zc;
  logic [Z_W-1:0]     z_pre;
  logic               decide_now;

  assign zc    = z_q[idx_q*CHUNK_W +: CHUNK_W];
  assign z_pre = {y_q[Z_W-2:0], 1'b0} - {{(Z_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    z_d        = z_q;
    s_d        = s_q;
    ct_d       = ct_q;
    idx_d      = idx_q;
    decided_d  = decided_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    y_ack_d    = y_ack_q;
    rnd_req_d  = rnd_req_q;
    b_d        = b_q;
    b_stb_d    = b_stb_q;
    cu_d       = cu_q;
    decide_now = 1'b0;

    case (state_q)
      IDLE: begin
        y_ack_d = 1'b1;
        if (y_stb && y_ack_q) begin
          y_d     = y_in;
          ct_d    = ct_mode;
          s_d     = (32'(s) >= 32'(Z_W - 1)) ? SH_W'(Z_W - 1) : SH_W'(s);
          y_ack_d = 1'b0;
          state_d = PREP;
        end
      end
      PREP: begin
        z_d       = z_pre >> s_q;
        idx_d     = IDX_W'(NCH - 1);
        decided_d = 1'b0;
        res_d     = 1'b0;
        cnt_d     = '0;
        rnd_req_d = 1'b1;
        state_d   = REQ;
      end
      REQ: begin
        rnd_req_d = 1'b1;
        if (rnd_stb && rnd_req_q) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!decided_q && (rnd != zc)) begin
            decided_d  = 1'b1;
            res_d      = (rnd < zc);
            decide_now = 1'b1;
          end
          // Constant-time mode ignores the decision and always walks to chunk 0.
          if ((!ct_q && decide_now) || (idx_q == '0)) begin
            rnd_req_d = 1'b0;
            state_d   = DONE;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      default: begin
        rnd_req_d = 1'b0;
        if (b_stb_q && b_ack) begin
          b_stb_d = 1'b0;
          y_ack_d = 1'b1;
          state_d = IDLE;
        end else if (!b_stb_q) begin
          b_stb_d = 1'b1;
          b_d     = res_q;
          cu_d    = cnt_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      y_q       <= '0;
      z_q       <= '0;
      s_q       <= '0;
      ct_q      <= 1'b0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      res_q     <= 1'b0;
      cnt_q     <= '0;
      y_ack_q   <= 1'b0;
      rnd_req_q <= 1'b0;
      b_q       <= 1'b0;
      b_stb_q   <= 1'b0;
      cu_q      <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      z_q       <= z_d;
      s_q       <= s_d;
      ct_q      <= ct_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      y_ack_q   <= y_ack_d;
      rnd_req_q <= rnd_req_d;
      b_q       <= b_d;
      b_stb_q   <= b_stb_d;
      cu_q      <= cu_d;
    end
  end

  assign y_ack       = y_ack_q;
  assign rnd_req     = rnd_req_q;
  assign rnd_ack     = rnd_req_q;
  assign b           = b_q;
  assign b_stb       = b_stb_q;
  assign chunks_used = cu_q;

endmodule

// File: tb/tb_ber_exp_cmp.sv
// Bench for ber_exp_cmp: an 8-bit-chunk and a 16-bit-chunk instance, one active at a time,
// checked against a whole-number model of the Bernoulli comparison.
module tb_ber_exp_cmp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ct_mode, y_stb, rnd_stb, b_ack, sel;
  logic [63:0] y_in;
  logic [7:0]  s;
  logic [15:0] rnd;

  logic       y_ack8, rnd_ack8, rnd_req8, b8, b_stb8;
  logic [3:0] cu8;
  logic       y_ack16, rnd_ack16, rnd_req16, b16, b_stb16;
  logic [2:0] cu16;

  ber_exp_cmp #(.Z_W(64), .CHUNK_W(8), .S_W(8)) dut8 (
    .clk(clk), .rst(rst), .y_in(y_in), .s(s), .ct_mode(ct_mode),
    .y_stb(y_stb & ~sel), .y_ack(y_ack8),
    .rnd(rnd[7:0]), .rnd_stb(rnd_stb & ~sel), .rnd_ack(rnd_ack8), .rnd_req(rnd_req8),
    .b(b8), .b_stb(b_stb8), .b_ack(b_ack & ~sel), .chunks_used(cu8));

  ber_exp_cmp #(.Z_W(64), .CHUNK_W(16), .S_W(8)) dut16 (
    .clk(clk), .rst(rst), .y_in(y_in), .s(s), .ct_mode(ct_mode),
    .y_stb(y_stb & sel), .y_ack(y_ack16),
    .rnd(rnd), .rnd_stb(rnd_stb & sel), .rnd_ack(rnd_ack16), .rnd_req(rnd_req16),
    .b(b16), .b_stb(b_stb16), .b_ack(b_ack & sel), .chunks_used(cu16));

  logic       y_ack_s, rnd_ack_s, rnd_req_s, b_s, b_stb_s;
  logic [3:0] cu_s;
  assign y_ack_s   = sel ? y_ack16   : y_ack8;
  assign rnd_ack_s = sel ? rnd_ack16 : rnd_ack8;
  assign rnd_req_s = sel ? rnd_req16 : rnd_req8;
  assign b_s       = sel ? b16       : b8;
  assign b_stb_s   = sel ? b_stb16   : b_stb8;
  assign cu_s      = sel ? {1'b0, cu16} : cu8;

  int errors = 0;
  int checks = 0;
  logic [15:0] ch [8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] zval(input logic [63:0] yv, input int sv);
    int sh;
    sh = (sv > 63) ? 63 : sv;
    return (yv * 2 - 1) >> sh;
  endfunction

  // Reference: treat the chunk stream as one 64-bit number, first chunk most significant.
  function automatic void model(input logic [63:0] yv, input int sv, input bit ct, input int cw,
                                output bit eb, output int en);
    logic [63:0] z, r;
    int nch, p;
    nch = 64 / cw;
    z = zval(yv, sv);
    r = '0;
    for (int i = 0; i < nch; i++) r = (r << cw) | 64'(ch[i]);
    eb = (r < z);
    if (ct || r == z) en = nch;
    else begin
      p = 63;
      while (r[p] == z[p]) p--;
      en = nch - p / cw;
    end
  endfunction

  task automatic do_op(input logic [63:0] yv, input int sv, input bit ct,
                       input int stall_at, input int stall_len, input int hold);
    bit eb;
    int en, cw, k, cyc, pulses, stall_left, w, exp_lat;
    bit rq_chk;
    cw = sel ? 16 : 8;
    model(yv, sv, ct, cw, eb, en);
    w = 0;
    while (!y_ack_s && w < 20) begin @(negedge clk); w++; end
    chk("y_ack_ready", y_ack_s, 1);
    y_in = yv; s = 8'(sv); ct_mode = ct; y_stb = 1'b1;
    k = 0; pulses = 0; cyc = -1; stall_left = stall_len; rq_chk = 0;
    while (cyc < 200) begin
      @(negedge clk); cyc++;
      if (cyc == 0) begin y_stb = 1'b0; chk("y_ack_busy", y_ack_s, 0); end
      if (pulses == en && !rq_chk) begin chk("rnd_req_drop", rnd_req_s, 0); rq_chk = 1; end
      if (b_stb_s) break;
      rnd = ch[(k < 8) ? k : 7];
      rnd_stb = 1'b1;
      if (pulses == stall_at && stall_left > 0 && rnd_ack_s) begin
        rnd_stb = 1'b0; stall_left--;
      end
      if (rnd_stb && rnd_ack_s) begin pulses++; k++; end
    end
    rnd_stb = 1'b0;
    exp_lat = en + 2 + ((stall_at < en) ? stall_len : 0);
    chk("b_stb_seen", b_stb_s, 1);
    chk("b", b_s, eb);
    chk("chunks_used", cu_s, en);
    chk("rnd_ack_pulses", pulses, en);
    chk("latency", cyc, exp_lat);
    for (int h = 0; h < hold; h++) begin
      b_ack = 1'b0;
      @(negedge clk);
      chk("hold_stable", {b_stb_s, b_s, cu_s, y_ack_s, rnd_req_s}, {1'b1, eb, 4'(en), 1'b0, 1'b0});
    end
    b_ack = 1'b1;
    @(negedge clk);
    b_ack = 1'b0;
    chk("b_stb_clear", b_stb_s, 0);
    chk("b_keep", {b_s, cu_s}, {eb, 4'(en)});
  endtask

  task automatic gen_chunks(input logic [63:0] yv, input int sv);
    logic [63:0] z;
    int cw, nch;
    logic [15:0] mask;
    cw = sel ? 16 : 8; nch = 64 / cw; mask = sel ? 16'hFFFF : 16'h00FF;
    z = zval(yv, sv);
    for (int i = 0; i < 8; i++) begin
      if (i < nch && $urandom_range(0, 3) != 0) ch[i] = 16'(z >> ((nch - 1 - i) * cw)) & mask;
      else ch[i] = 16'($urandom) & mask;
    end
  endtask

  task automatic fill(input logic [15:0] first, input logic [15:0] rest);
    ch[0] = first;
    for (int i = 1; i < 8; i++) ch[i] = rest;
  endtask

  initial begin
    int pulses, k, w;
    logic [63:0] yv;
    rst = 1'b1; ct_mode = 0; y_stb = 0; rnd_stb = 0; b_ack = 0; sel = 0;
    y_in = '0; s = '0; rnd = '0;
    repeat (3) @(negedge clk);
    chk("reset8", {y_ack8, rnd_ack8, rnd_req8, b8, b_stb8, cu8}, 0);
    chk("reset16", {y_ack16, rnd_ack16, rnd_req16, b16, b_stb16, cu16}, 0);
    rst = 1'b0;

    fill(16'h00, 16'h00); do_op(64'h8000000000000000, 0, 0, 99, 0, 0);
    fill(16'hFF, 16'hFF); do_op(64'h8000000000000000, 0, 0, 99, 0, 0);
    fill(16'h01, 16'h00); do_op(64'h8000000000000000, 200, 0, 99, 0, 0);
    fill(16'h00, 16'h00); do_op(64'h8000000000000000, 200, 0, 99, 0, 1);
    fill(16'h10, 16'hFF); do_op(64'h4000000000000000, 0, 1, 99, 0, 0);
    fill(16'hFF, 16'hFF); do_op(64'h8000000000000000, 0, 0, 2, 4, 5);
    fill(16'h10, 16'hFF); do_op(64'h4000000000000000, 0, 1, 5, 3, 2);
    fill(16'h00, 16'h00); do_op(64'h0, 5, 0, 99, 0, 0);

    // Reset in the middle of a compare after three equal chunks.
    fill(16'hFF, 16'hFF);
    w = 0;
    while (!y_ack_s && w < 20) begin @(negedge clk); w++; end
    y_in = 64'h8000000000000000; s = 0; ct_mode = 0; y_stb = 1'b1;
    pulses = 0; k = 0; w = 0;
    while (pulses < 3 && w < 50) begin
      @(negedge clk); w++;
      y_stb = 1'b0;
      if (pulses < 3) begin
        rnd = ch[k]; rnd_stb = 1'b1;
        if (rnd_ack_s) begin pulses++; k++; end
      end
    end
    chk("pre_rst_pulses", pulses, 3);
    rst = 1'b1; rnd_stb = 1'b1;
    @(negedge clk);
    chk("mid_rst", {y_ack_s, rnd_ack_s, rnd_req_s, b_s, b_stb_s, cu_s}, 0);
    @(negedge clk);
    chk("mid_rst_hold", {rnd_ack_s, rnd_req_s, b_stb_s}, 0);
    rst = 1'b0; rnd_stb = 1'b0;
    fill(16'h00, 16'h00); do_op(64'h8000000000000000, 0, 0, 99, 0, 0);

    sel = 1'b1;
    fill(16'h0000, 16'h0000); do_op(64'h8000000000000000, 0, 0, 99, 0, 0);
    fill(16'hFFFF, 16'hFFFF); do_op(64'h8000000000000000, 0, 0, 1, 2, 3);
    fill(16'h1000, 16'hFFFF); do_op(64'h4000000000000000, 0, 1, 99, 0, 0);

    for (int it = 0; it < 24; it++) begin
      int sv, st_at, st_len, hold;
      bit ct;
      sel = it[0];
      yv = {$urandom, $urandom};
      if (it % 7 == 3) yv = '0;
      sv = ($urandom_range(0, 7) == 0) ? $urandom_range(64, 255) : $urandom_range(0, 63);
      ct = 1'($urandom_range(0, 1));
      st_at = $urandom_range(0, 7);
      st_len = $urandom_range(0, 3);
      hold = $urandom_range(0, 3);
      gen_chunks(yv, sv);
      do_op(yv, sv, ct, st_at, st_len, hold);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ber_exp_cmp.md
Name: ber_exp_cmp

Overview:
- Parametrised Bernoulli-exponential decision stage of the Falcon discrete Gaussian sampler; successor to the fixed 64-bit, byte-at-a-time sample-bit stage.
- Takes the scaled exponential ccs*exp(-x) in 2^63 fixed point, forms z = ((2*y)-1) >> s, and compares z MSB-first against PRNG chunks of width CHUNK_W.
- Outputs b = 1 exactly when the random value is less than z.
- Adds two features: a constant-time mode that always consumes every chunk, and a consumed-chunk count for PRNG accounting.

Parameters:
Z_W, 64, width of y and z in bits
CHUNK_W, 8, PRNG chunk width in bits; Z_W % CHUNK_W must be 0 (elaboration error otherwise)
NCH, Z_W/CHUNK_W, number of chunks (derived, not overridable)
S_W, 8, width of the shift input s

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
y_in  in  Z_W  fpr_expm_p63 result
s  in  S_W  right-shift amount, saturated to Z_W-1
ct_mode  in  1  1 = constant-time, 0 = lazy early exit
y_stb  in  1  y_in/s/ct_mode valid
y_ack  out  1  block ready for a new operand
rnd  in  CHUNK_W  PRNG chunk
rnd_stb  in  1  rnd valid
rnd_ack  out  1  chunk accepted this cycle
rnd_req  out  1  chunk requested (PRNG get strobe)
b  out  1  Bernoulli result
b_stb  out  1  result valid
b_ack  in  1  consumer accepts result
chunks_used  out  clog2(NCH+1)  chunks consumed for the current result

Behaviour:
- All outputs are registered.
- Reset values: y_ack=0, rnd_ack=0, rnd_req=0, b=0, b_stb=0, chunks_used=0, state=IDLE.
- rst has priority over everything. Asserting rst mid-operation discards the operation, drops all strobes and acks the next cycle, and consumes no further chunks.
- Transfer rule: a transfer occurs on any rising edge where stb and ack are both 1.
- States: IDLE, PREP, REQ, DONE.
- IDLE:
  - y_ack=1.
  - On y_stb&y_ack: latch y_in, ct_mode, and s_eff = min(s, Z_W-1); y_ack->0; go to PREP.
- PREP (one cycle):
  - z = ((y<<1) - 1) mod 2^Z_W, then logical right shift by s_eff. y=0 gives z = all ones >> s_eff.
  - idx = NCH-1; decided=0; res=0; cnt=0; go to REQ.
- REQ:
  - rnd_req=1 and rnd_ack=1.
  - On rnd_stb&rnd_ack, take zc = z[idx*CHUNK_W +: CHUNK_W] and increment cnt.
  - If decided=0 and rnd<zc: res=1, decided=1.
  - If decided=0 and rnd>zc: res=0, decided=1.
  - If rnd==zc: no change.
  - Lazy mode: newly decided -> DONE. Otherwise idx==0 -> DONE with res=0 (all chunks equal means rnd==z, so b=0). Otherwise idx--.
  - CT mode: later chunks never change res. Go to DONE only after idx==0 is consumed, so cnt=NCH always.
  - rnd_stb low: hold state, no count.
- DONE:
  - rnd_req and rnd_ack drop the cycle DONE is entered.
  - b=res, chunks_used=cnt, b_stb=1.
  - b, b_stb and chunks_used hold stable until b_ack. On b_stb&b_ack: b_stb->0; return to IDLE (y_ack=1 next cycle).
  - b and chunks_used keep their last value until the next DONE.
- Latency, with y_stb and rnd_stb held high: y accepted at edge N, PREP at N+1, first chunk at N+2, k-th chunk at N+1+k, b_stb high after edge N+2+k.
  - Lazy: k is the index of the deciding chunk.
  - CT: k = NCH.
- No new operand is accepted while busy (y_ack=0 outside IDLE).
- A result can be acked on the same edge b_stb is first seen high.

Test Plan:
- Z_W=64, CHUNK_W=8, lazy, y=0x8000000000000000, s=0 -> z=0xFFFFFFFFFFFFFFFF; rnd=0x00 -> b=1, chunks_used=1, b_stb 3 cycles after y accept.
- Same z, every rnd=0xFF -> all chunks equal -> b=0, chunks_used=8, rnd_req drops after 8th chunk.
- s=200 (saturates to 63), y=0x8000000000000000 -> z=1:
  - lazy, rnd=0x01 on first chunk -> b=0, chunks_used=1;
  - rnd=0x00 x7 then 0x00 -> b=1, chunks_used=8.
- ct_mode=1, y=0x4000000000000000, s=0 (z=0x7FFFFFFFFFFFFFFF), rnd sequence 0x10 then 0xFF x7 -> b=1, chunks_used=8, exactly 8 rnd_ack pulses.
- Backpressure:
  - rnd_stb low 4 cycles mid-compare -> no count advance;
  - b_ack low 5 cycles -> b_stb, b, chunks_used stable, y_ack=0.
- Assert rst during REQ after 3 chunks -> next cycle all outputs at reset values; new op afterwards correct. Repeat with CHUNK_W=16: first test gives chunks_used=1 and NCH=4 in the all-equal case.
